// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: run control and fetch data in, latched instruction and status out.
interface fetch_decode_stage_if #(
  parameter int unsigned PC_size = 16,
  parameter int unsigned DW      = 9,
  parameter int unsigned CNT_W   = 16
);
  logic               Start;
  logic               Flush;
  logic               Stall;
  logic [PC_size-1:0] PC_in;
  logic [DW-1:0]      Instruction_in;
  logic [PC_size-1:0] PC_out;
  logic [DW-1:0]      Instruction_out;
  logic               Valid_out;
  logic               FetchHold;
  logic               Done;
  logic [CNT_W-1:0]   InstCount;

  modport master (
    output Start, Flush, Stall, PC_in, Instruction_in,
    input  PC_out, Instruction_out, Valid_out, FetchHold, Done, InstCount
  );

  modport slave (
    input  Start, Flush, Stall, PC_in, Instruction_in,
    output PC_out, Instruction_out, Valid_out, FetchHold, Done, InstCount
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// Fetch-to-decode pipeline register with run/halt control, branch bubbles,
// HALT detection and a saturating retired-instruction counter.
module fetch_decode_stage #(
  parameter int unsigned    PC_size    = 16,
  parameter int unsigned    DW         = 9,
  parameter logic [DW-1:0]  HALT_INSTR = 9'h1FF,
  parameter int unsigned    CNT_W      = 16
) (
  input logic              CLK,
  input logic              Reset,
  fetch_decode_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t             state_q, state_d;
  logic [PC_size-1:0] pc_q, pc_d;
  logic [DW-1:0]      instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    // Start wins in every state; the fetch data present on that edge is stale.
    if (bus.Start) begin
      state_d = RUN;
      valid_d = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.Flush) begin
            valid_d = 1'b0;
          end else if (!bus.Stall) begin
            pc_d    = bus.PC_in;
            instr_d = bus.Instruction_in;
            valid_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (bus.Instruction_in == HALT_INSTR) begin
              state_d = HALTED;
              done_d  = 1'b1;
            end
          end
        end
        HALTED:  valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.PC_out          = pc_q;
  assign bus.Instruction_out = instr_q;
  assign bus.Valid_out       = valid_q;
  assign bus.Done            = done_q;
  assign bus.InstCount       = cnt_q;
  assign bus.FetchHold       = (state_q != RUN) | bus.Stall;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench: small fetch/ROM model drives the stage; a second CNT_W=4 build checks saturation.
module tb_fetch_decode_stage;

  logic CLK = 1'b0;
  logic Reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  fetch_decode_stage_if #(.PC_size(16), .DW(9), .CNT_W(16)) bus ();
  fetch_decode_stage_if #(.PC_size(16), .DW(9), .CNT_W(4))  bus4 ();

  fetch_decode_stage #(.PC_size(16), .DW(9), .HALT_INSTR(9'h1FF), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus)
  );
  fetch_decode_stage #(.PC_size(16), .DW(9), .HALT_INSTR(9'h1FF), .CNT_W(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .bus(bus4)
  );

  // Fetch model: Start loads start_addr, Branch (Flush) loads target, Halt freezes PC.
  logic [15:0] fpc;
  logic [15:0] start_addr;
  logic [15:0] target;

  function automatic logic [8:0] rom(input logic [15:0] a);
    return (a == 16'd5) ? 9'h1FF : (a[8:0] ^ 9'h0A5);
  endfunction

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)               fpc <= '0;
    else if (bus.Start)      fpc <= start_addr;
    else if (bus.Flush)      fpc <= target;
    else if (!bus.FetchHold) fpc <= fpc + 16'd1;
  end

  assign bus.PC_in          = fpc;
  assign bus.Instruction_in = rom(fpc);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] pc, input logic [8:0] ins,
                           input logic v, input logic d, input logic [15:0] cnt, input logic fh);
    check_eq({tag, ".pc"},    32'(bus.PC_out), 32'(pc));
    check_eq({tag, ".instr"}, 32'(bus.Instruction_out), 32'(ins));
    check_eq({tag, ".valid"}, 32'(bus.Valid_out), 32'(v));
    check_eq({tag, ".done"},  32'(bus.Done), 32'(d));
    check_eq({tag, ".cnt"},   32'(bus.InstCount), 32'(cnt));
    check_eq({tag, ".hold"},  32'(bus.FetchHold), 32'(fh));
  endtask

  initial begin
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Flush = 1'b0; bus.Stall = 1'b0;
    bus4.Start = 1'b0; bus4.Flush = 1'b0; bus4.Stall = 1'b0;
    bus4.PC_in = '0; bus4.Instruction_in = '0;
    start_addr = '0; target = '0;
    tick(); tick();
    check_out("reset", 16'd0, 9'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    Reset = 1'b0;
    bus.Flush = 1'b1; bus.Stall = 1'b1;
    tick();
    check_out("idle_ignore", 16'd0, 9'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    bus.Flush = 1'b0; bus.Stall = 1'b0;

    // Start at address 1, three instructions
    start_addr = 16'd1; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check_out("start", 16'd0, 9'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    tick(); check_out("run1", 16'd1, 9'h0A4, 1'b1, 1'b0, 16'd1, 1'b0);
    tick(); check_out("run2", 16'd2, 9'h0A7, 1'b1, 1'b0, 16'd2, 1'b0);
    tick(); check_out("run3", 16'd3, 9'h0A6, 1'b1, 1'b0, 16'd3, 1'b0);

    // Branch to 20: one bubble
    target = 16'd20; bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check_out("bubble", 16'd3, 9'h0A6, 1'b0, 1'b0, 16'd3, 1'b0);
    tick(); check_out("branch", 16'd20, 9'h0B1, 1'b1, 1'b0, 16'd4, 1'b0);

    // Stall three cycles
    bus.Stall = 1'b1;
    #1 check_eq("stall_hold_comb", 32'(bus.FetchHold), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 16'd20, 9'h0B1, 1'b1, 1'b0, 16'd4, 1'b1);
    end
    target = 16'd30; bus.Flush = 1'b1;
    tick();
    check_out("flush_stall", 16'd20, 9'h0B1, 1'b0, 1'b0, 16'd4, 1'b1);
    bus.Flush = 1'b0; bus.Stall = 1'b0;
    tick(); check_out("after_fs", 16'd30, 9'h0BB, 1'b1, 1'b0, 16'd5, 1'b0);

    // Restart at 4, HALT at PC 5
    start_addr = 16'd4; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check_out("restart", 16'd30, 9'h0BB, 1'b0, 1'b0, 16'd0, 1'b0);
    tick(); check_out("pc4", 16'd4, 9'h0A1, 1'b1, 1'b0, 16'd1, 1'b0);
    tick(); check_out("halt", 16'd5, 9'h1FF, 1'b1, 1'b1, 16'd2, 1'b1);
    tick(); check_out("halted1", 16'd5, 9'h1FF, 1'b0, 1'b1, 16'd2, 1'b1);
    bus.Flush = 1'b1; target = 16'd40;
    tick(); check_out("halted2", 16'd5, 9'h1FF, 1'b0, 1'b1, 16'd2, 1'b1);
    bus.Flush = 1'b0;
    start_addr = 16'd1; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check_out("resume", 16'd5, 9'h1FF, 1'b0, 1'b0, 16'd0, 1'b0);
    tick(); check_out("resume_run", 16'd1, 9'h0A4, 1'b1, 1'b0, 16'd1, 1'b0);

    // HALT word on input during Stall and Flush is not captured
    start_addr = 16'd5; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0; bus.Stall = 1'b1;
    tick(); check_out("halt_stall", 16'd1, 9'h0A4, 1'b0, 1'b0, 16'd0, 1'b1);
    bus.Stall = 1'b0; bus.Flush = 1'b1; target = 16'd5;
    tick(); check_out("halt_flush", 16'd1, 9'h0A4, 1'b0, 1'b0, 16'd0, 1'b0);
    bus.Flush = 1'b0;
    tick(); check_out("halt_late", 16'd5, 9'h1FF, 1'b1, 1'b1, 16'd1, 1'b1);

    // Reset asserted between edges mid-run
    start_addr = 16'd1; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick(); check_out("pre_reset", 16'd1, 9'h0A4, 1'b1, 1'b0, 16'd1, 1'b0);
    #2 Reset = 1'b1;
    #1 check_out("async_reset", 16'd0, 9'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    tick();
    Reset = 1'b0;
    tick(); check_out("post_reset", 16'd0, 9'd0, 1'b0, 1'b0, 16'd0, 1'b1);

    // CNT_W=4 build saturates at 15
    bus4.Start = 1'b1;
    tick();
    bus4.Start = 1'b0;
    check_eq("sat_start", 32'(bus4.InstCount), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      bus4.PC_in = 16'(i);
      tick();
      if (i == 1)  check_eq("sat_1",  32'(bus4.InstCount), 32'd1);
      if (i == 14) check_eq("sat_14", 32'(bus4.InstCount), 32'd14);
      if (i == 15) check_eq("sat_15", 32'(bus4.InstCount), 32'd15);
      if (i == 16) check_eq("sat_16", 32'(bus4.InstCount), 32'd15);
      if (i == 20) check_eq("sat_20", 32'(bus4.InstCount), 32'd15);
    end
    check_eq("sat_pc", 32'(bus4.PC_out), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
